// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Purpose:
//   Fetch stage between the program counter, the instruction memory and the
//   decode stage. It issues one memory request per instruction, captures the
//   returned word, presents it to decode with a valid/ready handshake and
//   tells the program counter when to advance. Branch and jump redirects from
//   execute cancel the in-flight or pending instruction; a memory request
//   that is already outstanding is held until acknowledged and its data is
//   thrown away.
//
// Ports:
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous, active-low reset
//   pc_in        in  16   current PC from the program counter
//   pc_control   out  2   PC command: 00 hold, 01 increment, 10 branch, 11 jump
//   branch_req   in   1   branch redirect from execute
//   jump_req     in   1   jump redirect from execute
//   imem_req     out  1   instruction memory request
//   imem_addr    out 16   instruction memory address
//   imem_ack     in   1   memory response valid (zero or more cycles latency)
//   imem_rdata   in  16   instruction word, valid with imem_ack
//   instr_out    out 16   fetched instruction to decode
//   instr_pc     out 16   address of instr_out
//   instr_valid  out  1   instr_out / instr_pc valid
//   instr_ready  in   1   decode accepts the instruction
// -----------------------------------------------------------------------------
module instruction_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc_in,
  output logic [1:0]  pc_control,
  input  logic        branch_req,
  input  logic        jump_req,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr_out,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  // ---------------------------------------------------------------------------
  // State encoding and PC commands
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE  = 2'd0;  // out of reset, no request
  localparam logic [1:0] ST_FETCH = 2'd1;  // request at pc_in outstanding
  localparam logic [1:0] ST_HOLD  = 2'd2;  // instruction presented to decode
  localparam logic [1:0] ST_DROP  = 2'd3;  // waiting out a cancelled request

  localparam logic [1:0] PC_HOLD   = 2'b00;
  localparam logic [1:0] PC_INC    = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [15:0] r_addr_q;       // address of the request issued last cycle
  logic [15:0] r_instr_out;
  logic [15:0] r_instr_pc;
  logic        r_instr_valid;

  // ---------------------------------------------------------------------------
  // Decoded conditions
  // ---------------------------------------------------------------------------
  logic       w_in_fetch;
  logic       w_in_hold;
  logic       w_in_drop;
  logic       w_redirect;
  logic       w_accept;       // a returned word becomes a valid instruction
  logic       w_release;      // the presented instruction leaves this stage
  logic [1:0] w_state_nxt;

  assign w_in_fetch = (r_state == ST_FETCH);
  assign w_in_hold  = (r_state == ST_HOLD);
  assign w_in_drop  = (r_state == ST_DROP);
  assign w_redirect = branch_req | jump_req;

  // Data returned in the same cycle as a redirect belongs to the abandoned
  // path, so it is never accepted.
  assign w_accept   = w_in_fetch & imem_ack & ~w_redirect;

  // Any redirect kills a presented instruction; a redirect together with
  // instr_ready in HOLD counts as taken by decode, which ends the same way.
  assign w_release  = w_redirect | (w_in_hold & instr_ready);

  // ---------------------------------------------------------------------------
  // Memory interface
  // ---------------------------------------------------------------------------
  // The request follows the registered state only, so an asserted reset
  // drops it at once without waiting for an acknowledge.
  assign imem_req  = w_in_fetch | w_in_drop;

  // FETCH tracks the live PC (held stable by pc_control = 00 until the ack).
  // DROP must keep the original address because the PC has already moved to
  // the redirect target while the old request is still open.
  assign imem_addr = w_in_drop ? r_addr_q : pc_in;

  // ---------------------------------------------------------------------------
  // Program counter command
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default at the top;
  // a path that leaves it unassigned would infer a latch.
  always_comb begin
    pc_control = PC_HOLD;
    if (!reset) begin
      pc_control = PC_HOLD;
    end else if (jump_req) begin
      pc_control = PC_JUMP;
    end else if (branch_req) begin
      pc_control = PC_BRANCH;
    end else if (w_accept) begin
      pc_control = PC_INC;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        if (w_redirect) begin
          // With the ack in hand the old request is closed and fetching can
          // restart at the target; otherwise the request must be waited out.
          w_state_nxt = imem_ack ? ST_FETCH : ST_DROP;
        end else if (imem_ack) begin
          w_state_nxt = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (w_release) begin
          w_state_nxt = ST_FETCH;
        end
      end

      ST_DROP: begin
        // Further redirects only steer the PC; the open request still has
        // to complete before a new one may be issued.
        if (imem_ack) begin
          w_state_nxt = ST_FETCH;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and address capture
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_addr_q <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      if (w_in_fetch) begin
        r_addr_q <= pc_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Decode-side output register
  // ---------------------------------------------------------------------------
  // instr_out / instr_pc load only on an accepted word, so they stay frozen
  // while decode stalls. pc_in is passed through untouched; wrap-around is the
  // program counter's business.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_out   <= 16'h0000;
      r_instr_pc    <= 16'h0000;
      r_instr_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_instr_out   <= imem_rdata;
        r_instr_pc    <= pc_in;
        r_instr_valid <= 1'b1;
      end else if (w_release) begin
        r_instr_valid <= 1'b0;
      end
    end
  end

  assign instr_out   = r_instr_out;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch. A small program-counter model reacts
// to pc_control and drives pc_in. Every instruction the stimulus expects
// decode to take is pushed into a scoreboard queue; a monitor pops and
// compares on each instr_valid && instr_ready handshake. Control outputs are
// checked directly against hand-computed values.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic [15:0] pc_in;
  logic [1:0]  pc_control;
  logic        branch_req;
  logic        jump_req;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  exp_t sb_q[$];

  logic [15:0] branch_target;
  logic [15:0] jump_target;
  logic [15:0] pc_model;

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc_in),
    .pc_control  (pc_control),
    .branch_req  (branch_req),
    .jump_req    (jump_req),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter model: wraps naturally at 16 bits.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_model <= 16'h0000;
    end else begin
      case (pc_control)
        2'b01:   pc_model <= pc_model + 16'h0001;
        2'b10:   pc_model <= branch_target;
        2'b11:   pc_model <= jump_target;
        default: pc_model <= pc_model;
      endcase
    end
  end
  assign pc_in = pc_model;

  task automatic check(input string name, input logic [15:0] actual,
                       input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)",
               name, actual, expected, $time);
    end
  endtask

  // Scoreboard monitor: compare every delivered instruction.
  always @(negedge clk) begin
    if (reset && instr_valid && instr_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_delivery: got instr 0x%04h pc 0x%04h, expected none (t=%0t)",
                 instr_out, instr_pc, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("deliver_instr", instr_out, e.instr);
        check("deliver_pc", instr_pc, e.pc);
      end
    end
  end

  // Inputs change just after the rising edge; outputs are sampled at the
  // falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  initial begin
    reset         = 1'b0;
    branch_req    = 1'b0;
    jump_req      = 1'b1;   // a redirect during reset must not reach the PC
    imem_ack      = 1'b0;
    imem_rdata    = 16'h0000;
    instr_ready   = 1'b0;
    branch_target = 16'h0000;
    jump_target   = 16'h0000;

    // ---- reset values ----
    probe();
    check("rst_pc_control", {14'h0, pc_control}, 16'h0000);
    check("rst_imem_req", {15'h0, imem_req}, 16'h0000);
    check("rst_instr_valid", {15'h0, instr_valid}, 16'h0000);
    check("rst_instr_out", instr_out, 16'h0000);
    check("rst_instr_pc", instr_pc, 16'h0000);
    step();
    jump_req = 1'b0;
    probe();
    step();
    reset = 1'b1;            // IDLE this cycle
    probe();
    check("idle_imem_req", {15'h0, imem_req}, 16'h0000);
    check("idle_pc_control", {14'h0, pc_control}, 16'h0000);

    // ---- first fetch, ack on the 2nd FETCH cycle ----
    step();                  // FETCH cycle 1
    probe();
    check("f1_imem_req", {15'h0, imem_req}, 16'h0001);
    check("f1_imem_addr", imem_addr, 16'h0000);
    check("f1_pc_control", {14'h0, pc_control}, 16'h0000);
    step();                  // FETCH cycle 2
    imem_ack   = 1'b1;
    imem_rdata = 16'h1234;
    sb_q.push_back('{instr: 16'h1234, pc: 16'h0000});
    probe();
    check("f2_pc_control", {14'h0, pc_control}, 16'h0001);
    check("f2_instr_valid", {15'h0, instr_valid}, 16'h0000);
    step();                  // HOLD
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;

    // ---- HOLD stalled for 5 cycles ----
    for (int i = 0; i < 5; i++) begin
      probe();
      check("hold_valid", {15'h0, instr_valid}, 16'h0001);
      check("hold_instr_out", instr_out, 16'h1234);
      check("hold_instr_pc", instr_pc, 16'h0000);
      check("hold_imem_req", {15'h0, imem_req}, 16'h0000);
      check("hold_pc_control", {14'h0, pc_control}, 16'h0000);
      step();
    end
    instr_ready = 1'b1;      // accepted this cycle
    probe();
    step();                  // FETCH at 0x0001
    instr_ready = 1'b0;
    probe();
    check("f_next_imem_req", {15'h0, imem_req}, 16'h0001);
    check("f_next_imem_addr", imem_addr, 16'h0001);
    check("f_next_valid", {15'h0, instr_valid}, 16'h0000);

    // ---- ack + jump in the same FETCH cycle: data dropped ----
    step();
    imem_ack    = 1'b1;
    imem_rdata  = 16'hAAAA;
    jump_req    = 1'b1;
    jump_target = 16'h0010;
    probe();
    check("ackjump_pc_control", {14'h0, pc_control}, 16'h0003);
    step();                  // FETCH at 0x0010
    imem_ack = 1'b0;
    jump_req = 1'b0;
    probe();
    check("ackjump_valid", {15'h0, instr_valid}, 16'h0000);
    check("ackjump_imem_req", {15'h0, imem_req}, 16'h0001);
    check("ackjump_imem_addr", imem_addr, 16'h0010);

    // ---- branch without ack: DROP, ack 3 cycles later ----
    step();
    branch_req    = 1'b1;
    branch_target = 16'h0040;
    instr_ready   = 1'b1;    // any delivery on the dropped path would show up
    probe();
    check("br_pc_control", {14'h0, pc_control}, 16'h0002);
    check("br_imem_addr", imem_addr, 16'h0010);
    step();                  // DROP cycle 1
    branch_req = 1'b0;
    probe();
    check("drop_imem_req", {15'h0, imem_req}, 16'h0001);
    check("drop_imem_addr", imem_addr, 16'h0010);
    check("drop_pc_control", {14'h0, pc_control}, 16'h0000);
    check("drop_valid", {15'h0, instr_valid}, 16'h0000);
    step();                  // DROP cycle 2
    probe();
    check("drop2_imem_addr", imem_addr, 16'h0010);
    step();                  // DROP cycle 3, late ack
    imem_ack   = 1'b1;
    imem_rdata = 16'hBEEF;
    probe();
    check("drop_ack_pc_control", {14'h0, pc_control}, 16'h0000);
    check("drop_ack_valid", {15'h0, instr_valid}, 16'h0000);
    step();                  // FETCH at branch target
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    probe();
    check("post_drop_imem_addr", imem_addr, 16'h0040);
    check("post_drop_imem_req", {15'h0, imem_req}, 16'h0001);
    check("post_drop_valid", {15'h0, instr_valid}, 16'h0000);

    // ---- fetch, then jump+branch in HOLD kills the instruction ----
    step();
    instr_ready = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = 16'h5A5A;
    probe();
    check("f40_pc_control", {14'h0, pc_control}, 16'h0001);
    step();                  // HOLD
    imem_ack      = 1'b0;
    jump_req      = 1'b1;
    branch_req    = 1'b1;
    jump_target   = 16'h0100;
    branch_target = 16'h0200;
    probe();
    check("both_pc_control", {14'h0, pc_control}, 16'h0003);
    check("both_instr_out", instr_out, 16'h5A5A);
    check("both_instr_pc", instr_pc, 16'h0040);
    step();                  // FETCH at 0x0100
    jump_req   = 1'b0;
    branch_req = 1'b0;
    probe();
    check("killed_valid", {15'h0, instr_valid}, 16'h0000);
    check("killed_imem_addr", imem_addr, 16'h0100);

    // ---- ready together with redirect in HOLD counts as accepted ----
    step();
    imem_ack   = 1'b1;
    imem_rdata = 16'h0F0F;
    sb_q.push_back('{instr: 16'h0F0F, pc: 16'h0100});
    probe();
    step();                  // HOLD
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    branch_req  = 1'b1;
    probe();
    check("rdybr_pc_control", {14'h0, pc_control}, 16'h0002);
    step();                  // FETCH at 0x0200
    instr_ready = 1'b0;
    branch_req  = 1'b0;
    probe();
    check("rdybr_valid", {15'h0, instr_valid}, 16'h0000);
    check("rdybr_imem_addr", imem_addr, 16'h0200);

    // ---- reset while in DROP ----
    step();
    branch_req    = 1'b1;
    branch_target = 16'h0300;
    probe();
    step();                  // DROP
    branch_req = 1'b0;
    probe();
    check("pre_rst_imem_req", {15'h0, imem_req}, 16'h0001);
    check("pre_rst_imem_addr", imem_addr, 16'h0200);
    step();
    reset      = 1'b0;
    imem_ack   = 1'b1;       // acknowledge arrives too late
    imem_rdata = 16'hDEAD;
    #1;
    check("async_rst_imem_req", {15'h0, imem_req}, 16'h0000);
    check("async_rst_pc_control", {14'h0, pc_control}, 16'h0000);
    check("async_rst_valid", {15'h0, instr_valid}, 16'h0000);
    check("async_rst_instr_out", instr_out, 16'h0000);
    check("async_rst_instr_pc", instr_pc, 16'h0000);
    probe();
    step();
    reset = 1'b1;            // IDLE with the stale ack still high
    probe();
    check("late_ack_pc_control", {14'h0, pc_control}, 16'h0000);
    check("late_ack_imem_req", {15'h0, imem_req}, 16'h0000);
    check("late_ack_valid", {15'h0, instr_valid}, 16'h0000);
    step();                  // FETCH at 0x0000, zero-latency ack
    imem_rdata = 16'h7777;
    sb_q.push_back('{instr: 16'h7777, pc: 16'h0000});
    probe();
    check("rst_refetch_addr", imem_addr, 16'h0000);
    check("rst_refetch_pc_control", {14'h0, pc_control}, 16'h0001);
    step();                  // HOLD
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    probe();
    step();                  // FETCH at 0x0001
    instr_ready = 1'b0;
    probe();
    check("rst_next_addr", imem_addr, 16'h0001);

    // ---- PC wrap is passed through unchanged ----
    step();
    imem_ack    = 1'b1;
    imem_rdata  = 16'h1111;
    jump_req    = 1'b1;
    jump_target = 16'hFFFF;
    probe();
    step();                  // FETCH at 0xFFFF
    jump_req   = 1'b0;
    imem_rdata = 16'h4242;
    sb_q.push_back('{instr: 16'h4242, pc: 16'hFFFF});
    probe();
    check("wrap_imem_addr", imem_addr, 16'hFFFF);
    check("wrap_pc_control", {14'h0, pc_control}, 16'h0001);
    step();                  // HOLD, PC wrapped to 0x0000
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    probe();
    step();                  // FETCH at 0x0000
    instr_ready = 1'b0;
    probe();
    check("wrap_next_addr", imem_addr, 16'h0000);
    check("wrap_next_req", {15'h0, imem_req}, 16'h0001);

    step();
    check("scoreboard_drained", 16'(sb_q.size()), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
